// File: rtl/sel2_1_arb.sv
`default_nettype none
// ============================================================================
// Module   : sel2_1_arb
// Purpose  : Two-source round-robin arbiter that drives the SEL input of a
//            2-to-1 selector. Tracks per-owner burst length, hands ownership
//            over on LAST, burst limit or abandon with no idle bubble, and
//            breaks ties in favour of the source that did not own last.
// Ports    : CLK       - clock, all state on rising edge
//            RST       - synchronous active-high reset
//            REQ_A/B   - source A/B has a valid beat
//            LAST_A/B  - current beat ends the source's transfer
//            READY     - downstream accepts the presented beat
//            SEL       - selector control, 0 = A, 1 = B (registered)
//            GNT_A/B   - ownership grants (registered, one-hot or zero)
//            OUT_VALID - selector output carries a valid beat (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module sel2_1_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic LAST_A,
  input  logic LAST_B,
  input  logic READY,
  output logic SEL,
  output logic GNT_A,
  output logic GNT_B,
  output logic OUT_VALID
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] c_MAX_BURST = CW'(MAX_BURST);
  localparam logic [CW-1:0] c_ONE       = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_prev;      // last owner: 0 = A, 1 = B
  logic            r_sel;
  logic            r_gnt_a;
  logic            r_gnt_b;

  logic            w_own_req;   // request of the current owner
  logic            w_own_last;  // LAST of the current owner
  logic            w_other_req; // request of the non-owner
  logic            w_beat;
  logic            w_rel;

  assign w_cnt_inc = r_cnt + c_ONE;

  always_comb begin
    w_own_req   = 1'b0;
    w_own_last  = 1'b0;
    w_other_req = 1'b0;
    w_beat      = 1'b0;
    w_rel       = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;

    case (r_state)
      S_IDLE: begin
        // On a tie, r_prev names the last owner; grant the other one.
        if (REQ_A && REQ_B) begin
          w_state_nxt = r_prev ? S_OWN_A : S_OWN_B;
        end else if (REQ_A) begin
          w_state_nxt = S_OWN_A;
        end else if (REQ_B) begin
          w_state_nxt = S_OWN_B;
        end
      end

      S_OWN_A, S_OWN_B: begin
        w_own_req   = (r_state == S_OWN_A) ? REQ_A  : REQ_B;
        w_own_last  = (r_state == S_OWN_A) ? LAST_A : LAST_B;
        w_other_req = (r_state == S_OWN_A) ? REQ_B  : REQ_A;
        w_beat      = w_own_req & READY;
        // Abandon releases even under stall; LAST/limit need a real beat.
        w_rel       = ~w_own_req |
                      (w_beat & (w_own_last | (w_cnt_inc == c_MAX_BURST)));

        if (w_rel) begin
          w_cnt_nxt = '0;
          if (w_other_req) begin
            w_state_nxt = (r_state == S_OWN_A) ? S_OWN_B : S_OWN_A;
          end else if (w_own_req) begin
            // Non-abandon release with nobody else waiting: fresh burst.
            w_state_nxt = r_state;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 1'b1;
      r_sel   <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_rel) begin
        r_prev <= (r_state == S_OWN_B);
      end
      // Grants and SEL are registered copies of the next state so they are
      // valid right after the deciding edge; SEL holds through IDLE.
      r_gnt_a <= (w_state_nxt == S_OWN_A);
      r_gnt_b <= (w_state_nxt == S_OWN_B);
      if (w_state_nxt == S_OWN_A) begin
        r_sel <= 1'b0;
      end else if (w_state_nxt == S_OWN_B) begin
        r_sel <= 1'b1;
      end
    end
  end

  assign SEL       = r_sel;
  assign GNT_A     = r_gnt_a;
  assign GNT_B     = r_gnt_b;
  assign OUT_VALID = (r_gnt_a & REQ_A) | (r_gnt_b & REQ_B);

endmodule
`default_nettype wire
